// File: rtl/stream_mux_2x1_rr.sv
// Two-input packet stream merger: round-robin between packets, grant held until
// the last beat, registered output stage with valid/ready backpressure.
module stream_mux_2x1_rr #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_last,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_src,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prio;
    logic   prio_nxt;
    logic   out_free;
    logic   s0_xfer;
    logic   s1_xfer;

    // Output register can take a new beat when empty or draining this cycle
    assign out_free = !m_valid || m_ready;
    assign s0_xfer  = s0_valid && s0_ready;
    assign s1_xfer  = s1_valid && s1_ready;

    // State and priority pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Arbitration, packet lock and source ready generation
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (s0_valid && (!s1_valid || !prio)) begin
                    state_nxt = LOCK0;
                end else if (s1_valid) begin
                    state_nxt = LOCK1;
                end
            end
            LOCK0: begin
                s0_ready = out_free;
                if (s0_valid && out_free && s0_last) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b1;
                end
            end
            LOCK1: begin
                s1_ready = out_free;
                if (s1_valid && out_free && s1_last) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered output beat; contents held stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_src   <= 1'b0;
        end else if (s0_xfer) begin
            m_valid <= 1'b1;
            m_data  <= s0_data;
            m_last  <= s0_last;
            m_src   <= 1'b0;
        end else if (s1_xfer) begin
            m_valid <= 1'b1;
            m_data  <= s1_data;
            m_last  <= s1_last;
            m_src   <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
